// File: rtl/sig_capture_packer.sv
// Serial-to-word capture stage: samples the CAN RX bit stream on a bit-time
// strobe, packs bits MSB-first into words and issues one-cycle write pulses.
module sig_capture_packer #(
  parameter int unsigned WORD_W      = 32,
  parameter int unsigned CNT_W       = 16,
  parameter bit          TRIG_ON_SOF = 1'b1
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              sampleEn,
  input  logic              rxBit,
  input  logic              arm,
  input  logic              abort,
  input  logic [CNT_W-1:0]  startAddr,
  input  logic [CNT_W-1:0]  numWords,
  input  logic              wrFull,
  output logic [WORD_W-1:0] sendData,
  output logic              pulseWrite,
  output logic [CNT_W-1:0]  requestAddr_write,
  output logic [CNT_W-1:0]  numWrites,
  output logic              writeReq,
  output logic [CNT_W-1:0]  wordCount,
  output logic              done,
  output logic              overflow
);

  localparam int unsigned BitW = $clog2(WORD_W);
  localparam int unsigned PadW = BitW + 1;

  typedef enum logic [2:0] {StIdle, StTrig, StCapture, StFlush, StDone} state_e;

  state_e              state_q, state_d;
  logic [WORD_W-1:0]   shift_q, shift_d;
  logic [BitW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [WORD_W-1:0]   send_data_q;
  logic                pulse_q;
  logic [CNT_W-1:0]    addr_q, num_q, word_count_q;
  logic                overflow_q;

  logic                arm_ok, trig_hit, take_bit, word_done, last_word, flush_fire, emit;
  logic [PadW-1:0]     pad_amt;
  logic [WORD_W-1:0]   flush_word, emit_word;

  // Datapath control decode shared by the FSM and the datapath register
  always_comb begin
    arm_ok     = arm && (state_q == StIdle || state_q == StDone);
    trig_hit   = !rxBit || !TRIG_ON_SOF;
    // Abort in TRIG wins over a simultaneous trigger sample
    take_bit   = sampleEn && ((state_q == StCapture) ||
                              (state_q == StTrig && !abort && trig_hit));
    word_done  = take_bit && (bit_cnt_q == BitW'(WORD_W - 1));
    last_word  = (word_count_q + CNT_W'(1)) == num_q;
    flush_fire = (state_q == StFlush);
    emit       = word_done || flush_fire;
    shift_d    = {shift_q[WORD_W-2:0], rxBit};
    pad_amt    = PadW'(WORD_W) - {1'b0, bit_cnt_q};
    flush_word = shift_q << pad_amt;
    emit_word  = flush_fire ? flush_word : shift_d;
    bit_cnt_d  = bit_cnt_q;
    if (flush_fire) begin
      bit_cnt_d = '0;
    end else if (take_bit) begin
      bit_cnt_d = word_done ? '0 : bit_cnt_q + BitW'(1);
    end
  end

  // State register
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (arm) state_d = (numWords == '0) ? StDone : StTrig;
      end
      StTrig: begin
        if (abort) begin
          state_d = StDone;
        end else if (take_bit) begin
          state_d = StCapture;
        end
      end
      StCapture: begin
        // The sample is shifted in before abort is considered
        if (word_done && last_word) begin
          state_d = StDone;
        end else if (abort) begin
          state_d = (bit_cnt_d == '0) ? StDone : StFlush;
        end
      end
      StFlush: state_d = StDone;
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    done     = (state_q == StDone);
    writeReq = (state_q == StTrig) || (state_q == StCapture) || (state_q == StFlush);
  end

  // Shift register, bit counter, word emission and latched arm parameters
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      send_data_q  <= '0;
      pulse_q      <= 1'b0;
      addr_q       <= '0;
      num_q        <= '0;
      word_count_q <= '0;
      overflow_q   <= 1'b0;
    end else begin
      pulse_q <= 1'b0;
      if (arm_ok) begin
        addr_q       <= startAddr;
        num_q        <= numWords;
        word_count_q <= '0;
        overflow_q   <= 1'b0;
        bit_cnt_q    <= '0;
      end else begin
        bit_cnt_q <= bit_cnt_d;
        if (take_bit) shift_q <= shift_d;
        if (emit) begin
          // A dropped word still counts so capture always terminates
          word_count_q <= word_count_q + CNT_W'(1);
          if (wrFull) begin
            overflow_q <= 1'b1;
          end else begin
            pulse_q     <= 1'b1;
            send_data_q <= emit_word;
          end
        end
      end
    end
  end

  assign sendData          = send_data_q;
  assign pulseWrite        = pulse_q;
  assign requestAddr_write = addr_q;
  assign numWrites         = num_q;
  assign wordCount         = word_count_q;
  assign overflow          = overflow_q;

endmodule

// File: tb/tb_sig_capture_packer.sv
// Scoreboarded bench for sig_capture_packer: a bit-queue reference model
// pushes expected words, an independent monitor pops them on pulseWrite.
module tb_sig_capture_packer;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        sampleEn = 1'b0, rxBit = 1'b1, arm = 1'b0, abort = 1'b0, wrFull = 1'b0;
  logic [15:0] startAddr = '0, numWords = '0;
  logic [31:0] sendData;
  logic        pulseWrite, writeReq, done, overflow;
  logic [15:0] requestAddr_write, numWrites, wordCount;

  sig_capture_packer #(.WORD_W(32), .CNT_W(16), .TRIG_ON_SOF(1'b1)) dut (
    .clk(clk), .resetN(resetN), .sampleEn(sampleEn), .rxBit(rxBit), .arm(arm),
    .abort(abort), .startAddr(startAddr), .numWords(numWords), .wrFull(wrFull),
    .sendData(sendData), .pulseWrite(pulseWrite), .requestAddr_write(requestAddr_write),
    .numWrites(numWrites), .writeReq(writeReq), .wordCount(wordCount), .done(done),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int n_pulse = 0;

  // Reference model state
  logic [31:0] exp_q[$];
  logic [7:0]  full_mask = '0;
  logic [31:0] m_acc;
  int          m_nbits, m_words, m_numw;
  bit          m_trig, m_active, m_drop;
  logic [15:0] exp_addr, exp_num;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every write pulse must match the head of the expected queue
  always @(negedge clk) begin
    if (resetN && pulseWrite) begin
      n_pulse++;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_pulse: got 0x%08h expected no pulse", sendData);
      end else begin
        check("sendData", sendData, exp_q.pop_front());
      end
    end
  end

  task automatic model_emit(input logic [31:0] w);
    if (full_mask[m_words[2:0]]) m_drop = 1'b1;
    else exp_q.push_back(w);
    m_words++;
  endtask

  task automatic model_abort();
    if (m_active && m_trig && m_nbits > 0) model_emit(m_acc << (32 - m_nbits));
    m_active = 1'b0;
  endtask

  task automatic raw_arm(input logic [15:0] addr, input logic [15:0] n);
    arm = 1'b1; startAddr = addr; numWords = n;
    @(negedge clk);
    arm = 1'b0; startAddr = 16'hDEAD; numWords = 16'hBEEF;
  endtask

  task automatic arm_dut(input logic [15:0] addr, input logic [15:0] n);
    m_acc = '0; m_nbits = 0; m_words = 0; m_numw = int'(n);
    m_trig = 1'b0; m_active = (n != 0); m_drop = 1'b0;
    exp_addr = addr; exp_num = n;
    raw_arm(addr, n);
  endtask

  task automatic send_bit(input logic b, input logic ab);
    wrFull = full_mask[m_words[2:0]];
    sampleEn = 1'b1; rxBit = b; abort = ab;
    @(negedge clk);
    sampleEn = 1'b0; abort = 1'b0; rxBit = 1'b1;
    if (m_active) begin
      if (!m_trig && b == 1'b0) m_trig = 1'b1;
      if (m_trig) begin
        m_acc = {m_acc[30:0], b};
        m_nbits++;
        if (m_nbits == 32) begin
          model_emit(m_acc);
          m_nbits = 0;
          if (m_words == m_numw) m_active = 1'b0;
        end
      end
    end
    if (ab) model_abort();
    @(negedge clk);
  endtask

  task automatic send_abort();
    wrFull = full_mask[m_words[2:0]];
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    model_abort();
    @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w, input int n);
    for (int i = 31; i > 31 - n; i--) send_bit(w[i], 1'b0);
  endtask

  task automatic finish_scenario(input string tag);
    for (int i = 0; i < 40 && !done; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    wrFull = 1'b0;
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_writeReq"}, 32'(writeReq), 32'd0);
    check({tag, "_wordCount"}, 32'(wordCount), 32'(m_words));
    check({tag, "_overflow"}, 32'(overflow), 32'(m_drop));
    check({tag, "_addr"}, 32'(requestAddr_write), 32'(exp_addr));
    check({tag, "_numWrites"}, 32'(numWrites), 32'(exp_num));
    check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    repeat (3) @(negedge clk);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pulse", 32'(pulseWrite), 32'd0);
    check("rst_writeReq", 32'(writeReq), 32'd0);
    resetN = 1'b1;
    @(negedge clk);

    // 1: idle ones, then two known words
    arm_dut(16'd0, 16'd2);
    check("s1_writeReq", 32'(writeReq), 32'd1);
    repeat (5) send_bit(1'b1, 1'b0);
    send_word(32'h6F3B2A1C, 32);
    send_word(32'h12345678, 32);
    finish_scenario("s1");
    check("s1_held", sendData, 32'h12345678);

    // 2: one word plus a byte, then abort -> flushed partial word
    arm_dut(16'd4, 16'd3);
    send_word(32'h2468ACE0, 32);
    send_word(32'hA5000000, 8);
    send_abort();
    finish_scenario("s2");
    check("s2_flush", sendData, 32'hA5000000);

    // 3: wrFull during the second of three words
    full_mask = 8'b0000_0010;
    arm_dut(16'd16, 16'd3);
    send_word(32'h0BADF00D, 32);
    send_word(32'hCAFEBABE, 32);
    send_word(32'h13579BDF, 32);
    finish_scenario("s3");
    full_mask = '0;

    // 4: zero-length capture
    p0 = n_pulse;
    arm_dut(16'd2, 16'd0);
    check("s4_done", 32'(done), 32'd1);
    check("s4_writeReq", 32'(writeReq), 32'd0);
    finish_scenario("s4");
    check("s4_nopulse", 32'(n_pulse - p0), 32'd0);

    // 5: reset in the middle of a capture, then a clean capture
    arm_dut(16'd5, 16'd2);
    send_word(32'h3C3C3C3C, 20);
    resetN = 1'b0;
    #1;
    check("s5_data", sendData, 32'd0);
    check("s5_flags", {28'd0, pulseWrite, writeReq, done, overflow}, 32'd0);
    check("s5_counts", {requestAddr_write, wordCount}, 32'd0);
    check("s5_num", 32'(numWrites), 32'd0);
    exp_q.delete();
    @(negedge clk);
    resetN = 1'b1;
    @(negedge clk);
    arm_dut(16'd8, 16'd1);
    send_word(32'h55AA33CC, 32);
    finish_scenario("s5");

    // 6: arm ignored mid-capture; abort together with the 32nd bit
    arm_dut(16'd3, 16'd2);
    send_word(32'h3C5A0F96, 10);
    raw_arm(16'd77, 16'd9);
    for (int i = 21; i > 0; i--) send_bit(1'b0 ^ logic'((32'h3C5A0F96 >> i) & 1), 1'b0);
    send_bit(1'b0, 1'b1);
    finish_scenario("s6");
    check("s6_word", sendData, 32'h3C5A0F96);

    // Randomised captures with random backpressure and aborts
    for (int it = 0; it < 16; it++) begin
      int abort_at;
      full_mask = 8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255));
      arm_dut(16'($urandom), 16'($urandom_range(1, 4)));
      abort_at = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 140)) : -1;
      for (int i = 0; i < 300 && m_active; i++) begin
        if (i == abort_at) begin
          if (m_trig && $urandom_range(0, 1) == 1) send_bit(1'($urandom), 1'b1);
          else send_abort();
        end else begin
          send_bit(1'($urandom), 1'b0);
        end
      end
      finish_scenario("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
